sine_analyzer: RTL

- Receive-side counterpart to the LUT sine generator: consumes the generator's 16-bit sine stream and its 17-bit shifted/doubled companion stream.
- Per cycle of channel A, measures:
  - period in samples
  - min/max of each channel
  - phase lag from channel A to channel B
- Sits directly downstream of the generator in the practical's top level. Results drive LEDs/ILA probes and self-checking benches.

---
 rtl/sine_analyzer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/sine_analyzer.sv
// Receive-side analyzer for the LUT sine generator: measures period, per-channel
// extremes and A-to-B phase lag once per channel-A cycle, using rising midscale crossings.
module sine_analyzer #(
    parameter int          CW    = 16,
    parameter logic [15:0] MID_A = 16'h8000,
    parameter logic [16:0] MID_B = 17'h10000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sample_valid,
    input  logic [15:0]   sample_a,
    input  logic [16:0]   sample_b,
    output logic          locked,
    output logic          result_valid,
    output logic [CW-1:0] period,
    output logic [CW-1:0] phase,
    output logic          phase_valid,
    output logic [15:0]   max_a,
    output logic [15:0]   min_a,
    output logic [16:0]   max_b,
    output logic [16:0]   min_b,
    output logic          timeout
);

    typedef enum logic {SEEK, MEASURE} state_t;

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    state_t        state, state_nxt;
    logic          have_prev;
    logic [15:0]   prev_a;
    logic [16:0]   prev_b;
    logic          cross_a, cross_b;
    logic [CW-1:0] cnt, phase_acc;
    logic          b_seen;
    logic [15:0]   trk_max_a, trk_min_a;
    logic [16:0]   trk_max_b, trk_min_b;
    logic          cnt_full, start, publish, expire, track;

    // have_prev suppresses a bogus crossing against the reset value of prev_*.
    assign cross_a  = have_prev && (prev_a < MID_A) && (sample_a >= MID_A);
    assign cross_b  = have_prev && (prev_b < MID_B) && (sample_b >= MID_B);
    assign cnt_full = (cnt == CNT_MAX);

    assign start   = sample_valid && cross_a;
    assign publish = sample_valid && cross_a && (state == MEASURE);
    assign expire  = sample_valid && !cross_a && cnt_full && (state == MEASURE);
    assign track   = sample_valid && !cross_a && !cnt_full && (state == MEASURE);

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values, regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= SEEK;
        else     state <= state_nxt;
    end

    // NOTE: default assignment first, so no path leaves state_nxt unassigned (no latch).
    always_comb begin
        state_nxt = state;
        if (sample_valid) begin
            case (state)
                SEEK:    if (cross_a) state_nxt = MEASURE;
                MEASURE: if (!cross_a && cnt_full) state_nxt = SEEK;
                default: state_nxt = SEEK;
            endcase
        end
    end

    always_comb begin
        locked = (state == MEASURE);
    end

    // NOTE: every register here, results included, is plain flops and is cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            have_prev    <= 1'b0;
            prev_a       <= '0;
            prev_b       <= '0;
            cnt          <= '0;
            phase_acc    <= '0;
            b_seen       <= 1'b0;
            trk_max_a    <= '0;
            trk_min_a    <= '0;
            trk_max_b    <= '0;
            trk_min_b    <= '0;
            result_valid <= 1'b0;
            timeout      <= 1'b0;
            period       <= '0;
            phase        <= '0;
            phase_valid  <= 1'b0;
            max_a        <= '0;
            min_a        <= '0;
            max_b        <= '0;
            min_b        <= '0;
        end else begin
            result_valid <= 1'b0;
            timeout      <= 1'b0;
            if (sample_valid) begin
                prev_a    <= sample_a;
                prev_b    <= sample_b;
                have_prev <= 1'b1;
            end
            // Results cover the crossing sample up to, not including, this one.
            if (publish) begin
                result_valid <= 1'b1;
                period       <= cnt;
                phase        <= phase_acc;
                phase_valid  <= b_seen;
                max_a        <= trk_max_a;
                min_a        <= trk_min_a;
                max_b        <= trk_max_b;
                min_b        <= trk_min_b;
            end
            if (start) begin
                cnt       <= CW'(1);
                phase_acc <= '0;
                b_seen    <= cross_b;
                trk_max_a <= sample_a;
                trk_min_a <= sample_a;
                trk_max_b <= sample_b;
                trk_min_b <= sample_b;
            end else if (track) begin
                cnt <= cnt + CW'(1);
                if (sample_a > trk_max_a) trk_max_a <= sample_a;
                if (sample_a < trk_min_a) trk_min_a <= sample_a;
                if (sample_b > trk_max_b) trk_max_b <= sample_b;
                if (sample_b < trk_min_b) trk_min_b <= sample_b;
                if (cross_b && !b_seen) begin
                    phase_acc <= cnt;
                    b_seen    <= 1'b1;
                end
            end
            if (expire) timeout <= 1'b1;
        end
    end

endmodule
